// File: rtl/up_down_sweep_ctrl_if.sv
// Purpose: bundles the sweep controller's control, config, counter-feedback
//          and status signals.
// Ports:   master - drives start/stop/cfg_* and cnt_in, observes status
//          slave  - the controller side
interface up_down_sweep_ctrl_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SWEEP_W = 8
);
  logic               start;
  logic               stop;
  logic [WIDTH-1:0]   cfg_lo;
  logic [WIDTH-1:0]   cfg_hi;
  logic [SWEEP_W-1:0] cfg_n;
  logic [WIDTH-1:0]   cnt_in;
  logic               up_down;
  logic               cnt_reset;
  logic               busy;
  logic               done;
  logic               cfg_err;
  logic               fault;
  logic [SWEEP_W-1:0] sweeps;

  modport master (
    output start, stop, cfg_lo, cfg_hi, cfg_n, cnt_in,
    input  up_down, cnt_reset, busy, done, cfg_err, fault, sweeps
  );

  modport slave (
    input  start, stop, cfg_lo, cfg_hi, cfg_n, cnt_in,
    output up_down, cnt_reset, busy, done, cfg_err, fault, sweeps
  );
endinterface

// File: rtl/up_down_sweep_ctrl.sv
// Purpose: sequences an up/down counter through N triangle sweeps between LO
//          and HI, then parks it at 0. Shadows the expected counter value and
//          raises a sticky fault when the fed-back count diverges.
// Ports:   clk, reset (synchronous, active-high)
//          bus.slave: start/stop/cfg_lo/cfg_hi/cfg_n/cnt_in in;
//                     up_down/cnt_reset/busy/done/cfg_err/fault/sweeps out
module up_down_sweep_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SWEEP_W = 8
) (
  input logic                 clk,
  input logic                 reset,
  up_down_sweep_ctrl_if.slave bus
);
  // One extra bit so cfg_lo+2 cannot overflow in the validity check.
  localparam int unsigned CMP_W = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [SWEEP_W-1:0] n_q, n_d;
  logic [WIDTH-1:0]   exp_q, exp_d;
  logic [SWEEP_W-1:0] sweeps_q, sweeps_d;
  logic               up_down_q, up_down_d;
  logic               cnt_reset_q, cnt_reset_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;
  logic               fault_q, fault_d;
  logic               cfg_ok;
  logic [SWEEP_W-1:0] sweeps_inc;
  logic [WIDTH-1:0]   exp_step;

  assign cfg_ok     = (CMP_W'(bus.cfg_hi) >= (CMP_W'(bus.cfg_lo) + CMP_W'(2)))
                      && (bus.cfg_n != '0);
  assign sweeps_inc = sweeps_q + SWEEP_W'(1);
  // Shadow follows the direction the counter was told to move this cycle.
  assign exp_step   = up_down_q ? (exp_q + WIDTH'(1)) : (exp_q - WIDTH'(1));

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      n_q         <= '0;
      exp_q       <= '0;
      sweeps_q    <= '0;
      up_down_q   <= 1'b1;
      cnt_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      n_q         <= n_d;
      exp_q       <= exp_d;
      sweeps_q    <= sweeps_d;
      up_down_q   <= up_down_d;
      cnt_reset_q <= cnt_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      fault_q     <= fault_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    n_d         = n_q;
    exp_d       = exp_q;
    sweeps_d    = sweeps_q;
    up_down_d   = up_down_q;
    cnt_reset_d = cnt_reset_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    fault_d     = fault_q;

    if ((state_q != IDLE) && (bus.cnt_in != exp_q)) begin
      fault_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        exp_d       = '0;
        up_down_d   = 1'b1;
        cnt_reset_d = 1'b1;
        if (bus.start && !bus.stop) begin
          if (cfg_ok) begin
            lo_d        = bus.cfg_lo;
            hi_d        = bus.cfg_hi;
            n_d         = bus.cfg_n;
            sweeps_d    = '0;
            fault_d     = 1'b0;
            cnt_reset_d = 1'b0;
            busy_d      = 1'b1;
            state_d     = UP;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      UP: begin
        exp_d = exp_step;
        if (bus.stop) begin
          state_d     = IDLE;
          cnt_reset_d = 1'b1;
          up_down_d   = 1'b1;
          busy_d      = 1'b0;
        end else if (bus.cnt_in == (hi_q - WIDTH'(1))) begin
          // Counter lands on HI this edge and then heads down.
          up_down_d = 1'b0;
          state_d   = DOWN;
        end
      end

      DOWN: begin
        exp_d = exp_step;
        if (bus.stop) begin
          state_d     = IDLE;
          cnt_reset_d = 1'b1;
          up_down_d   = 1'b1;
          busy_d      = 1'b0;
        end else if (bus.cnt_in == (lo_q + WIDTH'(1))) begin
          sweeps_d = sweeps_inc;
          if (sweeps_inc == n_q) begin
            // Counter shows LO for one cycle before the reset clears it.
            state_d     = IDLE;
            cnt_reset_d = 1'b1;
            up_down_d   = 1'b1;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
            up_down_d = 1'b1;
            state_d   = UP;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        cnt_reset_d = 1'b1;
        up_down_d   = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  assign bus.up_down   = up_down_q;
  assign bus.cnt_reset = cnt_reset_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.fault     = fault_q;
  assign bus.sweeps    = sweeps_q;
endmodule
